// File: rtl/bypass_net_pkg.sv
// Shared definitions for the bypass network: datapath defaults and the
// one-hot bit positions of the DC-stage memory-op vector {lb,lbu,lh,lhu,lw}.
package bypass_net_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int MEM_OP_W = 5;
  localparam int MOP_LW   = 0;
  localparam int MOP_LHU  = 1;
  localparam int MOP_LH   = 2;
  localparam int MOP_LBU  = 3;
  localparam int MOP_LB   = 4;

  typedef logic [MEM_OP_W-1:0] mem_op_t;

endpackage

// File: rtl/load_align.sv
// Load alignment: extracts the byte/halfword/word addressed by the low two
// address bits from a raw 32-bit cache word and sign- or zero-extends it.
// Misaligned halfwords (offset 1 or 3) produce zero.
module load_align
  import bypass_net_pkg::*;
(
  input  mem_op_t     mem_op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        half_ok;

  // Pick the addressed byte/halfword and extend according to the one-hot op
  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    half_ok  = ~off[0];
    data     = '0;
    if (mem_op[MOP_LB]) begin
      data = {{24{byte_sel[7]}}, byte_sel};
    end else if (mem_op[MOP_LBU]) begin
      data = {24'b0, byte_sel};
    end else if (mem_op[MOP_LH]) begin
      data = half_ok ? {{16{half_sel[15]}}, half_sel} : 32'b0;
    end else if (mem_op[MOP_LHU]) begin
      data = half_ok ? {16'b0, half_sel} : 32'b0;
    end else if (mem_op[MOP_LW]) begin
      data = rdata;
    end
  end

endmodule

// File: rtl/bypass_net.sv
// Operand bypass network: for every register read port, finds the youngest
// producer stage writing the same register, raises a stall when that
// producer's result is not final yet, and registers the forwarded data.
// Load results in the DC stage are aligned here, and a capture register keeps
// the aligned value alive while DC and the following stage are both held.
module bypass_net
  import bypass_net_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int NUM_RD  = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DC_IDX  = 2,
  parameter int SKIP_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     id_hold,
  input  logic                     ex_hold,
  input  logic                     dc_hold,
  input  logic                     dc_next_hold,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic [NUM_SRC-1:0]       we,
  input  logic [NUM_SRC*ADDR_W-1:0] waddr,
  input  logic [NUM_SRC*DATA_W-1:0] wdata,
  input  logic [NUM_SRC-1:0]       rdy,
  input  mem_op_t                  dc_mem_op,
  input  logic [31:0]              dc_rdata,
  output logic                     stallreq,
  output logic [NUM_RD-1:0]        sel_fwd,
  output logic [NUM_RD*DATA_W-1:0] fwd_data
);

  logic [31:0]                     align_data;
  logic [DATA_W-1:0]               align_ext;
  logic                            cap_valid;
  logic [DATA_W-1:0]               cap_data;
  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data;
  logic [NUM_RD-1:0]               sel_nxt;
  logic [NUM_RD-1:0]               stall_port;
  logic [NUM_RD-1:0][DATA_W-1:0]   fwd_nxt;
  logic [NUM_RD-1:0]               sel_q;
  logic [NUM_RD-1:0][DATA_W-1:0]   fwd_q;

  load_align u_load_align (
    .mem_op (dc_mem_op),
    .off    (wdata[DC_IDX*DATA_W +: 2]),
    .rdata  (dc_rdata),
    .data   (align_data)
  );

  assign align_ext = DATA_W'(align_data);

  // Per-stage forwarding value; the DC stage substitutes load data on a load
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    if (s == DC_IDX) begin : g_dc
      assign src_data[s] = (|dc_mem_op) ? (cap_valid ? cap_data : align_ext)
                                        : wdata[s*DATA_W +: DATA_W];
    end else begin : g_plain
      assign src_data[s] = wdata[s*DATA_W +: DATA_W];
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_port
    logic [ADDR_W-1:0]  ra;
    logic               r0_blocked;
    logic [NUM_SRC-1:0] m;
    logic [DATA_W-1:0]  md;
    logic               st;

    assign ra         = raddr[r*ADDR_W +: ADDR_W];
    assign r0_blocked = (SKIP_R0 != 0) && (ra == '0);

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_match
      assign m[s] = we[s] & (waddr[s*ADDR_W +: ADDR_W] == ra) & ~r0_blocked;
    end

    // Walk oldest to youngest so the youngest matching stage is the one kept
    always_comb begin
      md = '0;
      st = 1'b0;
      for (int s = NUM_SRC-1; s >= 0; s--) begin
        if (m[s]) begin
          md = src_data[s];
          st = ~rdy[s];
        end
      end
    end

    assign sel_nxt[r]    = |m;
    assign stall_port[r] = st;
    assign fwd_nxt[r]    = md;
  end

  assign stallreq = |stall_port;

  // Capture register holds aligned load data while DC and its successor stall
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else if (!dc_hold && cap_valid) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else if (dc_hold && dc_next_hold && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_data  <= align_ext;
    end
  end

  // Output registers: bubble when ID holds but EX moves on, load when ID moves
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sel_q <= '0;
      fwd_q <= '0;
    end else if (id_hold && !ex_hold) begin
      sel_q <= '0;
      fwd_q <= '0;
    end else if (!id_hold) begin
      sel_q <= sel_nxt;
      fwd_q <= fwd_nxt;
    end
  end

  assign sel_fwd  = sel_q;
  assign fwd_data = fwd_q;

endmodule

// File: tb/tb_bypass_net.sv
// Directed testbench for bypass_net with default parameters
// (4 stages, 2 read ports, 32-bit data, 5-bit addresses, DC stage = 2).
module tb_bypass_net;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         id_hold;
  logic         ex_hold;
  logic         dc_hold;
  logic         dc_next_hold;
  logic [9:0]   raddr;
  logic [3:0]   we;
  logic [19:0]  waddr;
  logic [127:0] wdata;
  logic [3:0]   rdy;
  logic [4:0]   dc_mem_op;
  logic [31:0]  dc_rdata;
  logic         stallreq;
  logic [1:0]   sel_fwd;
  logic [63:0]  fwd_data;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [1:0]  off;
    logic [31:0] exp;
  } dc_vec_t;

  dc_vec_t dcVec [8];

  bypass_net dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .id_hold      (id_hold),
    .ex_hold      (ex_hold),
    .dc_hold      (dc_hold),
    .dc_next_hold (dc_next_hold),
    .raddr        (raddr),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .rdy          (rdy),
    .dc_mem_op    (dc_mem_op),
    .dc_rdata     (dc_rdata),
    .stallreq     (stallreq),
    .sel_fwd      (sel_fwd),
    .fwd_data     (fwd_data)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 unit after the last one
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    flush        = 1'b0;
    id_hold      = 1'b0;
    ex_hold      = 1'b0;
    dc_hold      = 1'b0;
    dc_next_hold = 1'b0;
    raddr        = '0;
    we           = '0;
    waddr        = '0;
    wdata        = '0;
    rdy          = '1;
    dc_mem_op    = '0;
    dc_rdata     = '0;
  endtask

  task automatic setStage(input int s, input logic w, input logic [4:0] a,
                          input logic [31:0] d, input logic r);
    we[s]            = w;
    waddr[s*5 +: 5]  = a;
    wdata[s*32 +: 32] = d;
    rdy[s]           = r;
  endtask

  initial begin
    dcVec[0] = '{op: 5'b10000, off: 2'd3, exp: 32'hFFFF_FF80};
    dcVec[1] = '{op: 5'b01000, off: 2'd3, exp: 32'h0000_0080};
    dcVec[2] = '{op: 5'b01000, off: 2'd1, exp: 32'h0000_00FF};
    dcVec[3] = '{op: 5'b00100, off: 2'd2, exp: 32'hFFFF_80FF};
    dcVec[4] = '{op: 5'b00010, off: 2'd0, exp: 32'h0000_FF00};
    dcVec[5] = '{op: 5'b00100, off: 2'd1, exp: 32'h0000_0000};
    dcVec[6] = '{op: 5'b00001, off: 2'd0, exp: 32'h80FF_FF00};
    dcVec[7] = '{op: 5'b00000, off: 2'd3, exp: 32'h1000_0003};

    // Reset, with a live not-ready match so stallreq must still show through
    clearInputs();
    rst = 1'b1;
    raddr[4:0] = 5'd5;
    setStage(0, 1'b1, 5'd5, 32'h11, 1'b0);
    #1;
    checkOutput("rst_stall_comb", 64'(stallreq), 64'd1);
    applyStimulus(1);
    checkOutput("rst_sel", 64'(sel_fwd), 64'd0);
    checkOutput("rst_data", fwd_data, 64'd0);
    checkOutput("rst_cap_valid", 64'(dut.cap_valid), 64'd0);
    applyStimulus(1);
    rst = 1'b0;

    // Youngest matching stage wins
    clearInputs();
    raddr = {5'd9, 5'd5};
    setStage(0, 1'b1, 5'd5, 32'h11, 1'b1);
    setStage(2, 1'b1, 5'd5, 32'h22, 1'b1);
    #1;
    checkOutput("prio_stall", 64'(stallreq), 64'd0);
    applyStimulus(1);
    checkOutput("prio_sel", 64'(sel_fwd), 64'b01);
    checkOutput("prio_data", fwd_data, 64'h0000_0000_0000_0011);

    // Not-ready older stage hidden behind a ready younger one does not stall
    rdy[2] = 1'b0;
    #1;
    checkOutput("unsel_notrdy", 64'(stallreq), 64'd0);
    we[0] = 1'b0;
    #1;
    checkOutput("sel_notrdy", 64'(stallreq), 64'd1);
    rdy[2] = 1'b1;
    applyStimulus(1);
    checkOutput("older_data", fwd_data, 64'h0000_0000_0000_0022);

    // Load-use: stage 0 not ready for port 1, then ID hold with EX moving
    raddr[9:5] = 5'd7;
    setStage(0, 1'b1, 5'd7, 32'h77, 1'b0);
    #1;
    checkOutput("loaduse_stall", 64'(stallreq), 64'd1);
    id_hold = 1'b1;
    ex_hold = 1'b0;
    applyStimulus(1);
    checkOutput("bubble_sel", 64'(sel_fwd), 64'd0);
    checkOutput("bubble_data", fwd_data, 64'd0);

    // Release, then verify a full hold keeps the registered values
    id_hold = 1'b0;
    rdy[0]  = 1'b1;
    applyStimulus(1);
    checkOutput("both_sel", 64'(sel_fwd), 64'b11);
    checkOutput("both_data", fwd_data, 64'h0000_0077_0000_0022);
    id_hold = 1'b1;
    ex_hold = 1'b1;
    wdata[31:0] = 32'h99;
    applyStimulus(1);
    checkOutput("hold_data", fwd_data, 64'h0000_0077_0000_0022);
    id_hold = 1'b0;
    ex_hold = 1'b0;
    applyStimulus(1);
    checkOutput("release_data", fwd_data, 64'h0000_0099_0000_0022);

    // DC stage load alignment table (raw word 0x80FF_FF00)
    clearInputs();
    raddr    = {5'd0, 5'd3};
    dc_rdata = 32'h80FF_FF00;
    for (int i = 0; i < 8; i++) begin
      dc_mem_op = dcVec[i].op;
      setStage(2, 1'b1, 5'd3, {30'h0400_0000, dcVec[i].off}, 1'b1);
      applyStimulus(1);
      checkOutput($sformatf("dc_vec%0d", i), fwd_data, {32'h0, dcVec[i].exp});
    end
    checkOutput("dc_sel", 64'(sel_fwd), 64'b01);

    // Capture: lhu at offset 2 survives the raw word changing while held
    dc_mem_op    = 5'b00010;
    setStage(2, 1'b1, 5'd3, 32'h2000_0002, 1'b1);
    dc_rdata     = 32'hBEEF_0000;
    dc_hold      = 1'b1;
    dc_next_hold = 1'b1;
    applyStimulus(1);
    checkOutput("cap_first", fwd_data, 64'h0000_BEEF);
    checkOutput("cap_valid_set", 64'(dut.cap_valid), 64'd1);
    dc_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("cap_hold%0d", i), fwd_data, 64'h0000_BEEF);
    end
    dc_hold = 1'b0;
    applyStimulus(1);
    checkOutput("cap_release", 64'(dut.cap_valid), 64'd0);
    checkOutput("cap_last_data", fwd_data, 64'h0000_BEEF);
    applyStimulus(1);
    checkOutput("cap_after", fwd_data, 64'd0);

    // Register 0 never matches
    clearInputs();
    setStage(0, 1'b1, 5'd0, 32'h55, 1'b0);
    #1;
    checkOutput("r0_stall", 64'(stallreq), 64'd0);
    applyStimulus(1);
    checkOutput("r0_sel", 64'(sel_fwd), 64'd0);
    checkOutput("r0_data", fwd_data, 64'd0);

    // Flush in the middle of a capture
    clearInputs();
    raddr        = {5'd9, 5'd3};
    dc_mem_op    = 5'b00010;
    setStage(2, 1'b1, 5'd3, 32'h2000_0002, 1'b1);
    setStage(3, 1'b1, 5'd9, 32'h33, 1'b1);
    dc_rdata     = 32'hBEEF_0000;
    dc_hold      = 1'b1;
    dc_next_hold = 1'b1;
    applyStimulus(1);
    checkOutput("pre_flush_cap", 64'(dut.cap_valid), 64'd1);
    checkOutput("pre_flush_data", fwd_data, 64'h0000_0033_0000_BEEF);
    flush = 1'b1;
    applyStimulus(1);
    checkOutput("flush_cap", 64'(dut.cap_valid), 64'd0);
    checkOutput("flush_sel", 64'(sel_fwd), 64'd0);
    checkOutput("flush_data", fwd_data, 64'd0);
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/bypass_net.md
BYPASS_NET -- requirements
Module: bypass_net

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of producer stages; index 0 is the youngest stage (EX), NUM_SRC-1 the oldest.
REQ-002 SHALL have parameter NUM_RD, default 2, number of register read ports.
REQ-003 SHALL have parameter DATA_W, default 32, datapath width.
REQ-004 SHALL have parameter ADDR_W, default 5, register address width.
REQ-005 SHALL have parameter DC_IDX, default 2, index of the data-cache stage.
REQ-006 SHALL have parameter SKIP_R0, default 1; when 1, address 0 never matches.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-009 SHALL have port flush, input, 1, pipeline flush.
REQ-010 SHALL have port id_hold, input, 1, ID stage held.
REQ-011 SHALL have port ex_hold, input, 1, EX stage held.
REQ-012 SHALL have port dc_hold, input, 1, DC stage held.
REQ-013 SHALL have port dc_next_hold, input, 1, stage after DC held.
REQ-014 SHALL have port raddr, input, NUM_RD*ADDR_W, read addresses; port r occupies slice r.
REQ-015 SHALL have port we, input, NUM_SRC, per-stage write enable.
REQ-016 SHALL have port waddr, input, NUM_SRC*ADDR_W, per-stage destination.
REQ-017 SHALL have port wdata, input, NUM_SRC*DATA_W, per-stage result; for the DC stage on a load this is the byte address.
REQ-018 SHALL have port rdy, input, NUM_SRC, per-stage flag: result final.
REQ-019 SHALL have port dc_mem_op, input, 5, one-hot {lb,lbu,lh,lhu,lw} for the DC stage.
REQ-020 SHALL have port dc_rdata, input, 32, raw data-cache read word.
REQ-021 SHALL have port stallreq, output, 1, hazard stall request (combinational).
REQ-022 SHALL have port sel_fwd, output, NUM_RD, registered: forward selected.
REQ-023 SHALL have port fwd_data, output, NUM_RD*DATA_W, registered forwarded data.

Function
REQ-024 SHALL compute match[r][s] = we[s] & (waddr[s]==raddr[r]) & ~(SKIP_R0 & raddr[r]==0).
REQ-025 SHALL select, per port, the lowest-index matching stage (youngest wins).
REQ-026 SHALL assert stallreq iff, for any port, the selected stage has rdy==0; stages that match but are not selected SHALL NOT affect stallreq.
REQ-027 SHALL drive the forwarding data from wdata[s] of the selected stage, except when s==DC_IDX and dc_mem_op!=0, where it SHALL use cap_valid ? cap_data : aligned load data.
REQ-028 SHALL form aligned load data using off = wdata[DC_IDX][1:0]:
- lb/lbu: byte off, sign-/zero-extended.
- lh/lhu: halfword at off 0 or 2, sign-/zero-extended; off 1 or 3 gives 0.
- lw: full word.
- no op: 0.
REQ-029 SHALL implement the capture register as follows, in priority order:
- rst or flush: clears cap_valid and cap_data.
- ~dc_hold & cap_valid: clears both.
- dc_hold & dc_next_hold & ~cap_valid: loads aligned data and sets cap_valid=1.
- otherwise: hold.
REQ-030 SHALL update the output registers as follows, in priority order:
- rst or flush: all zero.
- id_hold & ~ex_hold: zero (bubble).
- ~id_hold: load the combinational select and data.
- otherwise: hold.
REQ-031 SHALL give a 1-cycle latency from a raddr change to sel_fwd/fwd_data.
REQ-032 SHALL drive a port with no match as sel_fwd=0, data 0.

Reset
REQ-033 SHALL reset sel_fwd=0, fwd_data=0, cap_valid=0 and cap_data=0 on the first rising clk edge with rst=1.
REQ-034 SHALL NOT gate stallreq with rst; it follows the inputs combinationally.

Structure
REQ-035 SHALL place the mem-op one-hot bit positions and the DATA_W/ADDR_W defaults in the shared defines package.
REQ-036 SHALL implement the alignment in one sub-module, load_align (inputs mem_op, off, rdata; output data), instantiated once.
REQ-037 SHALL use generate loops over NUM_RD and NUM_SRC, with no hard-coded port count.

Verification
REQ-038 SHALL cover priority: raddr0=5, we={1,0,1,0}, waddr0=waddr2=5, wdata0=0x11, wdata2=0x22, rdy all 1 -> next cycle sel_fwd[0]=1, fwd_data0=0x11, stallreq=0.
REQ-039 SHALL cover load-use: stage0 matches raddr1=7 with rdy0=0 -> stallreq=1 in the same cycle; then id_hold=1, ex_hold=0 -> outputs zero after the edge.
REQ-040 SHALL cover DC lb: dc_mem_op=lb, wdata[DC]=0x...03, dc_rdata=0x80FF_FF00, match -> fwd_data=0xFFFF_FF80.
REQ-041 SHALL cover capture: a DC lhu match with off 2, dc_rdata=0xBEEF_0000, dc_hold=dc_next_hold=1 for 3 cycles while dc_rdata changes to 0 -> forwarded data stays 0x0000_BEEF; dc_hold drops -> cap_valid=0 next cycle.
REQ-042 SHALL cover R0 and flush: raddr=0 with we0=1, waddr0=0 -> sel_fwd=0; flush=1 mid-capture -> cap_valid=0 and outputs zero next cycle.
